// File: rtl/mtl_bus_pkg.sv
// Shared types, default window map and address-window decode helper for the MTL-1 bus window controller.
package mtl_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_HOLD   = 2'd3
  } mtl_state_e;

  localparam int          MTL_MAX_AW   = 32;
  localparam int          DEF_NUM_WIN  = 4;
  localparam int          DEF_AW       = 16;
  localparam int          DEF_WAIT_W   = 4;
  localparam logic [63:0] DEF_WIN_BASE = 64'hF000_A000_1000_0000;
  localparam logic [63:0] DEF_WIN_MASK = 64'hF000_E000_F000_F000;
  localparam logic [15:0] DEF_WIN_WAIT = 16'h2100;
  localparam logic [3:0]  DEF_WIN_HSK  = 4'b1010;
  localparam int          DEF_TIMEOUT  = 255;

  // A window hits when every compared address bit equals the base bit.
  function automatic logic mtl_win_hit(input logic [MTL_MAX_AW-1:0] addr,
                                       input logic [MTL_MAX_AW-1:0] base,
                                       input logic [MTL_MAX_AW-1:0] mask);
    return (((addr ^ base) & mask) == {MTL_MAX_AW{1'b0}});
  endfunction

endpackage

// File: rtl/mtl_sync_edge.sv
// Two-flop synchroniser for an asynchronous 6809 clock phase, with one-clock rise/fall pulses.
module mtl_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus one delay stage for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= async_in;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync_out = sync_r;
  assign rise     = sync_r & ~prev_r;
  assign fall     = ~sync_r & prev_r;

endmodule

// File: rtl/mtl_bus_window_ctrl.sv
// 6809 E-cycle sequencer for the MTL-1 adapter: window decode, wait/handshake stretch, strobes, DBEN.
// Optional handshake watchdog and sticky bus error enabled by defining MTL_BUS_TIMEOUT_EN.
module mtl_bus_window_ctrl
  import mtl_bus_pkg::*;
#(
  parameter int                       NUM_WIN  = DEF_NUM_WIN,
  parameter int                       AW       = DEF_AW,
  parameter int                       WAIT_W   = DEF_WAIT_W,
  parameter logic [NUM_WIN*AW-1:0]     WIN_BASE = DEF_WIN_BASE,
  parameter logic [NUM_WIN*AW-1:0]     WIN_MASK = DEF_WIN_MASK,
  parameter logic [NUM_WIN*WAIT_W-1:0] WIN_WAIT = DEF_WIN_WAIT,
  parameter logic [NUM_WIN-1:0]        WIN_HSK  = DEF_WIN_HSK
`ifdef MTL_BUS_TIMEOUT_EN
  , parameter int                     TIMEOUT  = DEF_TIMEOUT
`endif
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic                 i_E,
  input  logic                 i_Q,
  input  logic                 i_RW,
  input  logic [AW-1:0]        i_ADDRESS,
  input  logic [7:0]           i_wdata,
  input  logic [NUM_WIN*8-1:0] i_win_rdata,
  input  logic [NUM_WIN-1:0]   i_win_ready,
  output logic [NUM_WIN-1:0]   o_win_sel,
  output logic                 o_win_rd,
  output logic                 o_win_wr,
  output logic [7:0]           o_wdata,
  output logic [7:0]           o_rdata,
  output logic                 o_rdata_oe,
  output logic                 o_MRDY,
  output logic                 o_DBEN,
  output logic                 o_bus_err
);

  mtl_state_e state_r, state_nxt_s;
  logic [NUM_WIN-1:0] sel_r, sel_nxt_s, hit_sel_s;
  logic [WAIT_W-1:0]  cnt_r, cnt_nxt_s, hit_wait_s;
  logic               rw_r, rw_nxt_s;
  logic               rd_r, rd_nxt_s, wr_r, wr_nxt_s;
  logic [7:0]         rdata_r, rdata_nxt_s, wdata_r, wdata_nxt_s, rdata_mux_s;
  logic               oe_r, oe_nxt_s, dben_r, dben_nxt_s;
  logic               hsk_wait_s, wait_s;
  logic [MTL_MAX_AW-1:0] addr_ext_s, base_ext_s, mask_ext_s;
  logic e_rise_s, e_fall_s, e_sync_unused_s;
  logic q_sync_unused_s, q_rise_unused_s, q_fall_unused_s;

  mtl_sync_edge u_sync_e (
    .clk      (clk),
    .rst_n    (i_reset),
    .async_in (i_E),
    .sync_out (e_sync_unused_s),
    .rise     (e_rise_s),
    .fall     (e_fall_s)
  );

  // Q is carried through a synchroniser for status visibility only.
  mtl_sync_edge u_sync_q (
    .clk      (clk),
    .rst_n    (i_reset),
    .async_in (i_Q),
    .sync_out (q_sync_unused_s),
    .rise     (q_rise_unused_s),
    .fall     (q_fall_unused_s)
  );

  // Address decode: scan high to low so the lowest matching window wins.
  always_comb begin
    hit_sel_s  = {NUM_WIN{1'b0}};
    hit_wait_s = {WAIT_W{1'b0}};
    addr_ext_s = {MTL_MAX_AW{1'b0}};
    base_ext_s = {MTL_MAX_AW{1'b0}};
    mask_ext_s = {MTL_MAX_AW{1'b0}};
    addr_ext_s[AW-1:0] = i_ADDRESS;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      base_ext_s[AW-1:0] = WIN_BASE[i*AW +: AW];
      mask_ext_s[AW-1:0] = WIN_MASK[i*AW +: AW];
      if (mtl_win_hit(addr_ext_s, base_ext_s, mask_ext_s)) begin
        hit_sel_s  = NUM_WIN'(1) << i;
        hit_wait_s = WIN_WAIT[i*WAIT_W +: WAIT_W];
      end else begin
        hit_sel_s  = hit_sel_s;
        hit_wait_s = hit_wait_s;
      end
    end
  end

  // Per-window read mux and handshake status for the selected window.
  always_comb begin
    rdata_mux_s = 8'h00;
    for (int i = 0; i < NUM_WIN; i++) begin
      rdata_mux_s = rdata_mux_s | (sel_r[i] ? i_win_rdata[i*8 +: 8] : 8'h00);
    end
    hsk_wait_s = |(sel_r & WIN_HSK & ~i_win_ready);
    wait_s     = (cnt_r != {WAIT_W{1'b0}}) || hsk_wait_s;
  end

`ifdef MTL_BUS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_r, wd_nxt_s;
  logic            err_r, err_nxt_s;
`endif

  // Cycle sequencer: next state and next values of every registered output.
  always_comb begin
    state_nxt_s = state_r;
    sel_nxt_s   = sel_r;
    cnt_nxt_s   = cnt_r;
    rw_nxt_s    = rw_r;
    rd_nxt_s    = 1'b0;
    wr_nxt_s    = 1'b0;
    rdata_nxt_s = rdata_r;
    wdata_nxt_s = wdata_r;
    oe_nxt_s    = oe_r;
    dben_nxt_s  = dben_r;
`ifdef MTL_BUS_TIMEOUT_EN
    wd_nxt_s    = wd_r;
    err_nxt_s   = err_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (e_rise_s && (hit_sel_s != {NUM_WIN{1'b0}})) begin
          state_nxt_s = ST_ACCESS;
          sel_nxt_s   = hit_sel_s;
          cnt_nxt_s   = hit_wait_s;
          rw_nxt_s    = i_RW;
`ifdef MTL_BUS_TIMEOUT_EN
          wd_nxt_s    = {WD_W{1'b0}};
`endif
        end else begin
          sel_nxt_s = {NUM_WIN{1'b0}};
        end
      end
      ST_ACCESS: begin
        if (e_fall_s) begin
          state_nxt_s = ST_IDLE;
          sel_nxt_s   = {NUM_WIN{1'b0}};
          cnt_nxt_s   = {WAIT_W{1'b0}};
        end else if (!wait_s) begin
          state_nxt_s = ST_DONE;
          rd_nxt_s    = rw_r;
          wr_nxt_s    = !rw_r;
          if (rw_r) begin
            rdata_nxt_s = rdata_mux_s;
          end else begin
            wdata_nxt_s = i_wdata;
          end
`ifdef MTL_BUS_TIMEOUT_EN
        end else if (wd_r == WD_W'(TIMEOUT - 1)) begin
          // Watchdog expiry: complete the cycle with dummy read data, never write.
          state_nxt_s = ST_DONE;
          rd_nxt_s    = rw_r;
          err_nxt_s   = 1'b1;
          cnt_nxt_s   = {WAIT_W{1'b0}};
          if (rw_r) begin
            rdata_nxt_s = 8'hFF;
          end else begin
            rdata_nxt_s = rdata_r;
          end
`endif
        end else begin
          cnt_nxt_s = (cnt_r != {WAIT_W{1'b0}}) ? cnt_r - WAIT_W'(1) : cnt_r;
`ifdef MTL_BUS_TIMEOUT_EN
          wd_nxt_s  = wd_r + WD_W'(1);
`endif
        end
      end
      ST_DONE: begin
        if (e_fall_s) begin
          state_nxt_s = ST_IDLE;
          sel_nxt_s   = {NUM_WIN{1'b0}};
        end else begin
          state_nxt_s = ST_HOLD;
          dben_nxt_s  = 1'b0;
          oe_nxt_s    = rw_r;
        end
      end
      ST_HOLD: begin
        if (e_fall_s) begin
          state_nxt_s = ST_IDLE;
          sel_nxt_s   = {NUM_WIN{1'b0}};
          cnt_nxt_s   = {WAIT_W{1'b0}};
          oe_nxt_s    = 1'b0;
          dben_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        sel_nxt_s   = {NUM_WIN{1'b0}};
        cnt_nxt_s   = {WAIT_W{1'b0}};
        oe_nxt_s    = 1'b0;
        dben_nxt_s  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_r <= ST_IDLE;
      sel_r   <= {NUM_WIN{1'b0}};
      cnt_r   <= {WAIT_W{1'b0}};
      rw_r    <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      rdata_r <= 8'h00;
      wdata_r <= 8'h00;
      oe_r    <= 1'b0;
      dben_r  <= 1'b1;
`ifdef MTL_BUS_TIMEOUT_EN
      wd_r    <= {WD_W{1'b0}};
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_nxt_s;
      sel_r   <= sel_nxt_s;
      cnt_r   <= cnt_nxt_s;
      rw_r    <= rw_nxt_s;
      rd_r    <= rd_nxt_s;
      wr_r    <= wr_nxt_s;
      rdata_r <= rdata_nxt_s;
      wdata_r <= wdata_nxt_s;
      oe_r    <= oe_nxt_s;
      dben_r  <= dben_nxt_s;
`ifdef MTL_BUS_TIMEOUT_EN
      wd_r    <= wd_nxt_s;
      err_r   <= err_nxt_s;
`endif
    end
  end

  assign o_win_sel  = sel_r;
  assign o_win_rd   = rd_r;
  assign o_win_wr   = wr_r;
  assign o_wdata    = wdata_r;
  assign o_rdata    = rdata_r;
  assign o_rdata_oe = oe_r;
  assign o_DBEN     = dben_r;
  // MRDY follows the ready inputs directly so the strobe lands the clock after ready rises.
  assign o_MRDY     = !((state_r == ST_ACCESS) && wait_s);
`ifdef MTL_BUS_TIMEOUT_EN
  assign o_bus_err  = err_r;
`else
  assign o_bus_err  = 1'b0;
`endif

endmodule

// File: tb/tb_mtl_bus_window_ctrl.sv
// Directed plus randomized bench for mtl_bus_window_ctrl against a window-table reference model.
module tb_mtl_bus_window_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_E = 1'b0;
  logic        i_Q = 1'b0;
  logic        i_RW = 1'b1;
  logic [15:0] i_ADDRESS = 16'h0000;
  logic [7:0]  i_wdata = 8'h00;
  logic [31:0] i_win_rdata = 32'h0;
  logic [3:0]  i_win_ready = 4'hF;
  logic [3:0]  o_win_sel;
  logic        o_win_rd, o_win_wr, o_rdata_oe, o_MRDY, o_DBEN, o_bus_err;
  logic [7:0]  o_wdata, o_rdata;

  int checks = 0;
  int failures = 0;

  // Window table: index 0 is the least significant packed entry.
  int win_base[4] = '{32'h0000, 32'h1000, 32'hA000, 32'hF000};
  int win_mask[4] = '{32'hF000, 32'hF000, 32'hE000, 32'hF000};
  int win_wait[4] = '{0, 0, 1, 2};
  int win_hsk[4]  = '{0, 1, 0, 1};

  mtl_bus_window_ctrl dut (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_E         (i_E),
    .i_Q         (i_Q),
    .i_RW        (i_RW),
    .i_ADDRESS   (i_ADDRESS),
    .i_wdata     (i_wdata),
    .i_win_rdata (i_win_rdata),
    .i_win_ready (i_win_ready),
    .o_win_sel   (o_win_sel),
    .o_win_rd    (o_win_rd),
    .o_win_wr    (o_win_wr),
    .o_wdata     (o_wdata),
    .o_rdata     (o_rdata),
    .o_rdata_oe  (o_rdata_oe),
    .o_MRDY      (o_MRDY),
    .o_DBEN      (o_DBEN),
    .o_bus_err   (o_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_win(input logic [15:0] a);
    for (int i = 0; i < 4; i++) begin
      if (((32'(a) ^ win_base[i]) & win_mask[i]) == 0) return i;
    end
    return -1;
  endfunction

  task automatic check_reset_values();
    check("rst_sel", 32'(o_win_sel), 32'h0);
    check("rst_rd", 32'(o_win_rd), 32'h0);
    check("rst_wr", 32'(o_win_wr), 32'h0);
    check("rst_rdata", 32'(o_rdata), 32'h0);
    check("rst_oe", 32'(o_rdata_oe), 32'h0);
    check("rst_mrdy", 32'(o_MRDY), 32'h1);
    check("rst_dben", 32'(o_DBEN), 32'h1);
    check("rst_err", 32'(o_bus_err), 32'h0);
  endtask

  // One complete E cycle; rdly = ACCESS clocks before the window's ready rises.
  task automatic run_cycle(input logic [15:0] addr, input logic rw, input logic [7:0] wd, input int rdly);
    int w, low, lat;
    logic [7:0] rb[4];
    w = exp_win(addr);
    for (int i = 0; i < 4; i++) rb[i] = 8'($urandom);
    i_win_rdata = {rb[3], rb[2], rb[1], rb[0]};
    i_ADDRESS = addr;
    i_RW = rw;
    i_wdata = wd;
    i_win_ready = (rdly == 0) ? 4'hF : 4'h0;
    tick();
    i_Q = 1'b1;
    i_E = 1'b1;
    if (w < 0) begin
      for (int c = 0; c < 10; c++) begin
        tick();
        @(negedge clk);
        check("nomatch_idle", {26'h0, o_win_sel, o_win_rd, o_win_wr},  32'h0);
        check("nomatch_bus", {29'h0, o_rdata_oe, o_DBEN, o_MRDY}, 32'h3);
      end
      i_E = 1'b0;
      i_Q = 1'b0;
      repeat (6) tick();
      return;
    end
    lat = -1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      tick();
      @(negedge clk);
      if (o_win_sel != 4'h0) lat = c;
    end
    check("sel_latency", 32'(lat), 32'd2);
    check("sel_onehot", 32'(o_win_sel), 32'(1 << w));
    low = win_wait[w];
    if (win_hsk[w] != 0 && rdly > low) low = rdly;
    check("mrdy_k0", 32'(o_MRDY), (low > 0) ? 32'h0 : 32'h1);
    for (int k = 1; k <= low; k++) begin
      tick();
      i_win_ready = (k >= rdly) ? 4'hF : 4'h0;
      @(negedge clk);
      check("mrdy_wait", 32'(o_MRDY), (k < low) ? 32'h0 : 32'h1);
      check("no_early_strobe", {30'h0, o_win_rd, o_win_wr}, 32'h0);
    end
    tick();
    @(negedge clk);
    check("strobe", {30'h0, o_win_rd, o_win_wr}, rw ? 32'h2 : 32'h1);
    check("done_mrdy", 32'(o_MRDY), 32'h1);
    check("done_sel", 32'(o_win_sel), 32'(1 << w));
    if (rw) check("rdata", 32'(o_rdata), 32'(rb[w]));
    else    check("wdata", 32'(o_wdata), 32'(wd));
    tick();
    @(negedge clk);
    check("hold_strobe_off", {30'h0, o_win_rd, o_win_wr}, 32'h0);
    check("hold_dben", 32'(o_DBEN), 32'h0);
    check("hold_oe", 32'(o_rdata_oe), 32'(rw));
    repeat (3) tick();
    i_E = 1'b0;
    i_Q = 1'b0;
    lat = -1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      tick();
      @(negedge clk);
      if (o_DBEN) lat = c;
    end
    check("fall_latency", 32'(lat), 32'd2);
    check("idle_sel", 32'(o_win_sel), 32'h0);
    check("idle_oe", 32'(o_rdata_oe), 32'h0);
    repeat (2) tick();
  endtask

  initial begin
    logic [15:0] a;
    logic [3:0]  hi;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    i_reset = 1'b1;
    repeat (2) tick();

    run_cycle(16'h0010, 1'b1, 8'h00, 0);
    run_cycle(16'hF123, 1'b0, 8'h5A, 0);
    run_cycle(16'h1000, 1'b1, 8'h00, 20);
    run_cycle(16'hA000, 1'b1, 8'h00, 0);
    run_cycle(16'h9000, 1'b1, 8'h00, 0);

    // Reset asserted while a handshake window is still stretching the cycle.
    i_ADDRESS = 16'h1004;
    i_RW = 1'b1;
    i_win_ready = 4'h0;
    i_E = 1'b1;
    repeat (5) tick();
    check("pre_reset_mrdy", 32'(o_MRDY), 32'h0);
    #2;
    i_reset = 1'b0;
    #1;
    check_reset_values();
    i_E = 1'b0;
    repeat (3) tick();
    i_reset = 1'b1;
    repeat (3) tick();
    run_cycle(16'h1234, 1'b0, 8'hC3, 3);

    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 5))
        0: hi = 4'h0;
        1: hi = 4'h1;
        2: hi = 4'hA;
        3: hi = 4'hB;
        4: hi = 4'hF;
        default: hi = 4'($urandom);
      endcase
      a = {hi, 12'($urandom)};
      run_cycle(a, 1'($urandom), 8'($urandom), int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
